tpiu_frame_aligner: RTL and testbench
=====================================

Name: tpiu_frame_aligner

Overview:
Sits directly downstream of the trace pin capture stage: consumes the TPIU byte stream already in the system clock domain, hunts for the full sync word 0x7FFFFFFF, and assembles aligned 16-byte TPIU frames. Frames are buffered in a 2-deep FIFO and presented on a 128-bit valid/ready interface to the packetiser/UART sender. Reports sync status, aborted (broken) frames and overflow drops.

Parameters:
IDLE_LIMIT, 4096, system clocks with no in_valid before sync is declared lost
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_data  in  8  trace byte, first-received byte is frame byte 0
in_valid  in  1  one-cycle qualifier per byte
resync  in  1  force return to HUNT, discard partial frame
frame_data  out  128  frame, byte k at bits [8k+7:8k]
frame_valid  out  1  frame available
frame_ready  in  1  consumer accepts frame when valid&ready
synced  out  1  frame alignment held
frame_abort  out  1  one-cycle pulse: partial frame discarded by sync
ovf  out  1  one-cycle pulse: completed frame dropped, FIFO full
drop_cnt  out  CNT_W  saturating count of dropped frames

Behaviour:
- Reset (async): state HUNT; synced=0, frame_valid=0, frame_data=0, frame_abort=0, ovf=0, drop_cnt=0; FIFO empty, byte counter 0, sync history cleared. Reset mid-frame or with FIFO occupied discards everything.
- Sync detect: 32-bit history shifts in each valid byte (new byte at MSB); match when history == 0x7FFFFFFF (byte order FF,FF,FF,7F). Detection is active in both states.
- HUNT: non-sync bytes discarded. On match: -> SYNCED, byte counter 0; synced=1 the cycle after the 7F byte.
- SYNCED: each valid non-matching byte written to slot byte_cnt, byte_cnt++. When the 16th byte is written: frame pushed to FIFO, byte_cnt wraps to 0.
- Sync while SYNCED: byte_cnt reset to 0; the three FF bytes already written are discarded. If byte_cnt > 3 at detection, frame_abort pulses once the next cycle; byte_cnt <= 3 is a clean resync, no pulse. A sync straddling a frame boundary is not special-cased (TPIU only emits sync on frame boundaries).
- Idle timeout: counter cleared on every in_valid; reaching IDLE_LIMIT in SYNCED -> HUNT, synced=0, partial frame discarded, no abort pulse. Counter saturates in HUNT.
- resync=1: -> HUNT next cycle, synced=0, partial discarded; FIFO contents kept. resync has priority over a same-cycle sync match.
- FIFO: 2 entries, in-order. frame_valid registered; first frame visible the cycle after its 16th byte. Push to full FIFO: frame dropped, ovf pulses next cycle, drop_cnt++ saturating at all-ones. Push and pop in the same cycle when full: pop first, push accepted, no ovf.
- frame_data stable while frame_valid & !frame_ready.

Decomposition:
- Package tpiu_pkg: TPIU_SYNC_WORD = 32'h7FFFFFFF, FRAME_BYTES = 16, frame typedef (128-bit), state enum {HUNT, SYNCED}.
- Sub-module frame_fifo2: 2-entry 128-bit valid/ready FIFO with full/empty and simultaneous push/pop. Alignment FSM, sync history, byte counter and idle timer stay in the top.

Test Plan:
1. Bytes 00,01,02 then FF,FF,FF,7F then 00..0F, ready=1 -> pre-sync bytes ignored; synced=1 one cycle after 7F; one frame 128'h0F0E0D0C0B0A09080706050403020100; no abort.
2. Synced, ready=0, three frames of 00..0F -> first two held; ovf pulses once; drop_cnt=1. Then ready=1 -> two identical frames delivered in order, then frame_valid=0.
3. 00..05 then FF,FF,FF,7F then F,E,...,0 pattern (bytes FF..F0 descending) -> single frame_abort pulse, no frame from the 6 bytes; next frame 128'hF0F1...FEFF with byte 0 = FF.
4. Synced, 8 bytes, then IDLE_LIMIT idle cycles -> synced=0; following 16 bytes without sync produce no frame; after sync, frames resume.
5. One frame in FIFO (ready=0) plus 8 bytes partial, assert rst -> all outputs 0 immediately; after release, no frame until new sync.
6. FIFO full, ready=1 in the same cycle the 16th byte of a third frame arrives -> no ovf, drop_cnt unchanged, three frames delivered in order.

Source files
------------

// File: rtl/tpiu_pkg.sv
// Shared types and constants for the TPIU frame aligner.
package tpiu_pkg;

    localparam logic [31:0] TPIU_SYNC_WORD = 32'h7FFF_FFFF;
    localparam int unsigned FRAME_BYTES    = 16;
    localparam int unsigned FRAME_W        = FRAME_BYTES * 8;
    localparam int unsigned BCNT_W         = $clog2(FRAME_BYTES);

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } state_t;

endpackage

// File: rtl/tpiu_frame_aligner_fifo.sv
// Two-entry in-order frame FIFO with registered head/valid and same-cycle push/pop.
module frame_fifo2
    import tpiu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  frame_t i_data,
    input  logic   i_push,
    input  logic   i_ready,
    output frame_t o_data,
    output logic   o_valid,
    output logic   o_full_c
);

    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    frame_t     r_head;
    frame_t     r_tail;
    logic       r_valid;
    logic       w_pop;
    logic       w_accept;

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign w_pop    = r_valid & i_ready;
    assign w_accept = i_push & ((r_cnt != 2'd2) | w_pop);
    assign o_full_c = (r_cnt == 2'd2);
    assign o_data   = r_head;
    assign o_valid  = r_valid;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_pop && !w_accept) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end else if (w_accept && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != 2'd0);
            if (w_pop && w_accept) begin
                if (r_cnt == 2'd2) begin
                    r_head <= r_tail;
                    r_tail <= i_data;
                end else begin
                    r_head <= i_data;
                end
            end else if (w_pop) begin
                if (r_cnt == 2'd2) begin
                    r_head <= r_tail;
                end
            end else if (w_accept) begin
                if (r_cnt == 2'd0) begin
                    r_head <= i_data;
                end else begin
                    r_tail <= i_data;
                end
            end
        end
    end

endmodule

// File: rtl/tpiu_frame_aligner.sv
// TPIU byte-stream aligner: hunts for the full sync word and assembles 16-byte frames
// into a 2-deep FIFO, reporting sync state, aborted frames and overflow drops.
module tpiu_frame_aligner
    import tpiu_pkg::*;
#(
    parameter int unsigned IDLE_LIMIT = 4096,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               resync,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               synced,
    output logic               frame_abort,
    output logic               ovf,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [23:0]         r_hist;
    logic [31:0]         w_hist_nxt;
    logic                w_match;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [BCNT_W-1:0]   w_bcnt_nxt;
    logic [FRAME_W-9:0]  r_frame;
    frame_t              w_push_data;
    logic                w_wr_en;
    logic                w_push;
    logic                w_abort;
    logic                w_drop;
    logic [IDLE_W-1:0]   r_idle;
    logic                w_timeout;
    logic                r_synced;
    logic                r_abort;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                w_fifo_full;
    logic                w_fifo_valid;
    frame_t              w_fifo_data;

    // Newest byte enters at the MSB, so FF,FF,FF,7F completes the sync word
    assign w_hist_nxt  = {in_data, r_hist};
    assign w_match     = in_valid & (w_hist_nxt == TPIU_SYNC_WORD);
    assign w_timeout   = ~in_valid & (r_idle == IDLE_W'(IDLE_LIMIT - 1));
    assign w_push_data = {in_data, r_frame};
    assign w_drop      = w_push & w_fifo_full & ~(w_fifo_valid & frame_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_wr_en     = 1'b0;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (!resync && w_match) begin
                    w_state_nxt = SYNCED;
                    w_bcnt_nxt  = '0;
                end
            end
            SYNCED: begin
                if (resync || w_timeout) begin
                    w_state_nxt = HUNT;
                    w_bcnt_nxt  = '0;
                end else if (w_match) begin
                    // The three FF bytes were already written; only real data counts as an abort
                    w_bcnt_nxt = '0;
                    w_abort    = (r_bcnt > BCNT_W'(3));
                end else if (in_valid) begin
                    w_wr_en    = 1'b1;
                    w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                    w_push     = (r_bcnt == BCNT_W'(FRAME_BYTES - 1));
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_bcnt_nxt  = '0;
            end
        endcase
    end

    // Byte 15 goes straight into the pushed frame, so only 15 slots are stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            r_frame <= '0;
        end else begin
            if (in_valid) begin
                r_hist <= w_hist_nxt[31:8];
            end
            for (int unsigned k = 0; k < FRAME_BYTES - 1; k++) begin
                if (w_wr_en && (r_bcnt == BCNT_W'(k))) begin
                    r_frame[8*k +: 8] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (in_valid) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(IDLE_LIMIT)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_synced   <= 1'b0;
            r_abort    <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_synced <= (w_state_nxt == SYNCED);
            r_abort  <= w_abort;
            r_ovf    <= w_drop;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    frame_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_data   (w_push_data),
        .i_push   (w_push),
        .i_ready  (frame_ready),
        .o_data   (w_fifo_data),
        .o_valid  (w_fifo_valid),
        .o_full_c (w_fifo_full)
    );

    assign frame_data  = w_fifo_data;
    assign frame_valid = w_fifo_valid;
    assign synced      = r_synced;
    assign frame_abort = r_abort;
    assign ovf         = r_ovf;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_tpiu_frame_aligner.sv
// Directed bench for tpiu_frame_aligner: sync hunt, framing, abort, idle loss, reset, FIFO overflow.
module tb_tpiu_frame_aligner;

    localparam int unsigned LIM = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         resync;
    logic [127:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;
    logic         synced;
    logic         frame_abort;
    logic         ovf;
    logic [15:0]  drop_cnt;

    int tests   = 0;
    int fails   = 0;
    int n_abort = 0;
    int n_ovf   = 0;
    logic [127:0] q[$];

    tpiu_frame_aligner #(.IDLE_LIMIT(LIM), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .resync      (resync),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .synced      (synced),
        .frame_abort (frame_abort),
        .ovf         (ovf),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Capture pulses and delivered frames mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_abort) n_abort++;
            if (ovf) n_ovf++;
            if (frame_valid && frame_ready) q.push_back(frame_data);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_sync();
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'h7F);
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int k = 0; k < 16; k++) send(base + 8'(k));
    endtask

    function automatic logic [127:0] mkframe(input logic [7:0] base);
        logic [127:0] f;
        for (int k = 0; k < 16; k++) f[8*k +: 8] = base + 8'(k);
        return f;
    endfunction

    function automatic logic [127:0] qat(input int i);
        return (i < q.size()) ? q[i] : 128'd0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_synced"},  128'(synced),      128'd0);
        check({tag, "_valid"},   128'(frame_valid), 128'd0);
        check({tag, "_data"},    frame_data,        128'd0);
        check({tag, "_abort"},   128'(frame_abort), 128'd0);
        check({tag, "_ovf"},     128'(ovf),         128'd0);
        check({tag, "_dropcnt"}, 128'(drop_cnt),    128'd0);
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; resync = 1'b0; frame_ready = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // 1: pre-sync bytes ignored, sync, one clean frame
        send(8'h00); send(8'h01); send(8'h02);
        send(8'hFF); send(8'hFF); send(8'hFF);
        check("t1_presync", 128'(synced), 128'd0);
        send(8'h7F);
        check("t1_synced", 128'(synced), 128'd1);
        send_frame(8'h00);
        check("t1_valid", 128'(frame_valid), 128'd1);
        check("t1_head", frame_data, 128'h0F0E0D0C0B0A09080706050403020100);
        tick(3);
        check("t1_count", 128'(q.size()), 128'd1);
        check("t1_frame", qat(0), 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_abort", 128'(n_abort), 128'd0);

        // 2: backpressure, third frame dropped
        q.delete(); n_ovf = 0; frame_ready = 1'b0;
        send_frame(8'h00); send_frame(8'h00); send_frame(8'h00);
        tick(2);
        check("t2_valid", 128'(frame_valid), 128'd1);
        check("t2_head", frame_data, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t2_ovf", 128'(n_ovf), 128'd1);
        check("t2_dropcnt", 128'(drop_cnt), 128'd1);
        frame_ready = 1'b1;
        tick(4);
        check("t2_count", 128'(q.size()), 128'd2);
        check("t2_f0", qat(0), 128'h0F0E0D0C0B0A09080706050403020100);
        check("t2_f1", qat(1), 128'h0F0E0D0C0B0A09080706050403020100);
        check("t2_empty", 128'(frame_valid), 128'd0);

        // 3: sync mid-frame aborts the partial frame
        q.delete(); n_abort = 0;
        for (int k = 0; k < 6; k++) send(8'(k));
        send_sync();
        tick(2);
        check("t3_abort", 128'(n_abort), 128'd1);
        check("t3_nodata", 128'(frame_valid), 128'd0);
        for (int k = 0; k < 16; k++) send(8'hFF - 8'(k));
        tick(3);
        check("t3_count", 128'(q.size()), 128'd1);
        check("t3_frame", qat(0), 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        check("t3_abort_once", 128'(n_abort), 128'd1);

        // 4: idle timeout drops sync
        q.delete();
        for (int k = 0; k < 8; k++) send(8'hA0 + 8'(k));
        tick(LIM - 1);
        check("t4_still_synced", 128'(synced), 128'd1);
        tick(2);
        check("t4_lost", 128'(synced), 128'd0);
        send_frame(8'h40);
        tick(3);
        check("t4_noframe", 128'(q.size()), 128'd0);
        send_sync();
        send_frame(8'h50);
        tick(3);
        check("t4_resumed", 128'(q.size()), 128'd1);
        check("t4_frame", qat(0), mkframe(8'h50));
        check("t4_abort", 128'(n_abort), 128'd1);

        // 5: async reset with FIFO occupied and a partial frame holding FF,FF,FF
        q.delete(); frame_ready = 1'b0;
        send_frame(8'h60);
        for (int k = 0; k < 5; k++) send(8'h60 + 8'(k));
        send(8'hFF); send(8'hFF); send(8'hFF);
        check("t5_pre_valid", 128'(frame_valid), 128'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        tick(2);
        rst = 1'b0; frame_ready = 1'b1;
        tick(1);
        send(8'h7F);
        check("t5_hist_cleared", 128'(synced), 128'd0);
        send_frame(8'h70);
        tick(3);
        check("t5_noframe", 128'(q.size()), 128'd0);
        check("t5_unsynced", 128'(synced), 128'd0);

        // 6: full FIFO popped in the same cycle as a third push
        send_sync();
        q.delete(); n_ovf = 0; frame_ready = 1'b0;
        send_frame(8'h80);
        send_frame(8'h90);
        for (int k = 0; k < 15; k++) send(8'hA0 + 8'(k));
        frame_ready = 1'b1;
        send(8'hAF);
        tick(5);
        check("t6_ovf", 128'(n_ovf), 128'd0);
        check("t6_dropcnt", 128'(drop_cnt), 128'd0);
        check("t6_count", 128'(q.size()), 128'd3);
        check("t6_f0", qat(0), mkframe(8'h80));
        check("t6_f1", qat(1), mkframe(8'h90));
        check("t6_f2", qat(2), mkframe(8'hA0));
        check("t6_empty", 128'(frame_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
